// File: rtl/shot_pkg.sv
// Shared types, defaults and the enemy cooldown rule for the projectile shoot-request dispatcher.
package shot_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2
  } dispatch_state_t;

  typedef enum logic {
    OWNER_PLAYER = 1'b0,
    OWNER_ENEMY  = 1'b1
  } owner_t;

  localparam int DEF_NUM_SLOTS              = 4;
  localparam int DEF_PLAYER_COOLDOWN_FRAMES = 8;
  localparam int DEF_ENEMY_BASE_COOLDOWN    = 40;
  localparam int DEF_LEVEL_COOLDOWN_STEP    = 3;
  localparam int DEF_ENEMY_MIN_COOLDOWN     = 10;
  localparam int DEF_ACK_TIMEOUT            = 3;

  // Internal dispatcher state, exposed for checkers and debug.
  typedef struct packed {
    dispatch_state_t state;
    owner_t          owner;
    logic            fireKeyPrev;
    logic            playerPend;
    logic            enemyPend;
    logic [7:0]      playerCd;
    logic [7:0]      enemyCd;
    logic [7:0]      ackCnt;
  } dispatch_dbg_t;

  // Signed arithmetic so high levels go negative before the floor is applied.
  function automatic logic [7:0] enemyCooldown(input logic [3:0] lvl, input int base,
                                               input int step, input int floorCd);
    int v;
    v = base - step * int'(lvl);
    if (v < floorCd) v = floorCd;
    return 8'(v);
  endfunction

endpackage

// File: rtl/free_slot_finder.sv
// Lowest-index free-slot priority encoder over the projectile busy flags.
module free_slot_finder #(
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_SLOTS-1:0] beingShot,
  output logic [IDX_W-1:0]     index,
  output logic                 anyFree
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    index   = '0;
    anyFree = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!beingShot[i]) begin
        index   = IDX_W'(i);
        anyFree = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shot_dispatcher.sv
// Arbitrates player/enemy fire requests onto free projectile slots with level-scaled cooldowns.
// Optional AUTOFIRE_EN: a held fire key re-arms the player request whenever its cooldown is 0.
module shot_dispatcher
  import shot_pkg::*;
#(
  parameter int NUM_SLOTS              = DEF_NUM_SLOTS,
  parameter int PLAYER_COOLDOWN_FRAMES = DEF_PLAYER_COOLDOWN_FRAMES,
  parameter int ENEMY_BASE_COOLDOWN    = DEF_ENEMY_BASE_COOLDOWN,
  parameter int LEVEL_COOLDOWN_STEP    = DEF_LEVEL_COOLDOWN_STEP,
  parameter int ENEMY_MIN_COOLDOWN     = DEF_ENEMY_MIN_COOLDOWN,
  parameter int ACK_TIMEOUT            = DEF_ACK_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 fireKey,
  input  logic                 enemyFireReq,
  input  logic [NUM_SLOTS-1:0] beingShot,
  input  logic [3:0]           level,
  input  logic                 endLevel,
  output logic [NUM_SLOTS-1:0] shootRequestPlayer,
  output logic [NUM_SLOTS-1:0] shootRequestEnemy,
  output logic                 playerReady,
  output logic [15:0]          shotCount,
  output logic                 ackTimeout,
  output dispatch_dbg_t        dbg
);

  localparam int                   SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [NUM_SLOTS-1:0] SLOT_ONE  = NUM_SLOTS'(1);
  localparam logic [7:0]           PLAYER_CD = 8'(PLAYER_COOLDOWN_FRAMES);
  localparam logic [7:0]           ACK_LAST  = 8'(ACK_TIMEOUT - 1);

  dispatch_state_t   state;
  owner_t            owner;
  logic [SLOT_W-1:0] slot;
  logic [7:0]        ackCnt;
  logic              fireKeyPrev;
  logic              playerPend, enemyPend;
  logic [7:0]        playerCd, enemyCd;

  logic              playerPendD, enemyPendD;
  logic [7:0]        playerCdD, enemyCdD;
  logic [SLOT_W-1:0] freeIdx;
  logic              anyFree;
  logic              playerFire;
  logic              ack;

  free_slot_finder #(
    .NUM_SLOTS(NUM_SLOTS),
    .IDX_W    (SLOT_W)
  ) u_finder (
    .beingShot(beingShot),
    .index    (freeIdx),
    .anyFree  (anyFree)
  );

`ifdef AUTOFIRE_EN
  assign playerFire = fireKey;
`else
  assign playerFire = fireKey & ~fireKeyPrev;
`endif

  // Handshake: shootRequest* is a one-cycle one-hot pulse on the chosen slot; that slot
  // acknowledges by raising beingShot[slot] within ACK_TIMEOUT cycles of the pulse,
  // otherwise the pending request stays latched and is re-issued from IDLE.
  assign ack = (state == WAIT_ACK) && beingShot[slot];

  always_comb begin
    playerPendD = playerPend;
    enemyPendD  = enemyPend;
    playerCdD   = playerCd;
    enemyCdD    = enemyCd;
    if (startOfFrame && (playerCd != 8'd0)) playerCdD = playerCd - 8'd1;
    if (startOfFrame && (enemyCd != 8'd0))  enemyCdD  = enemyCd - 8'd1;
    if (playerFire && (playerCd == 8'd0))   playerPendD = 1'b1;
    if (enemyFireReq && (enemyCd == 8'd0))  enemyPendD  = 1'b1;
    // An ack reloads the cooldown even if a frame tick lands in the same cycle.
    if (ack && (owner == OWNER_PLAYER)) begin
      playerPendD = 1'b0;
      playerCdD   = PLAYER_CD;
    end
    if (ack && (owner == OWNER_ENEMY)) begin
      enemyPendD = 1'b0;
      enemyCdD   = enemyCooldown(level, ENEMY_BASE_COOLDOWN, LEVEL_COOLDOWN_STEP,
                                 ENEMY_MIN_COOLDOWN);
    end
    if (endLevel) begin
      playerPendD = 1'b0;
      enemyPendD  = 1'b0;
      playerCdD   = 8'd0;
      enemyCdD    = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state              <= IDLE;
      owner              <= OWNER_PLAYER;
      slot               <= '0;
      ackCnt             <= 8'd0;
      fireKeyPrev        <= 1'b0;
      playerPend         <= 1'b0;
      enemyPend          <= 1'b0;
      playerCd           <= 8'd0;
      enemyCd            <= 8'd0;
      shootRequestPlayer <= '0;
      shootRequestEnemy  <= '0;
      playerReady        <= 1'b0;
      shotCount          <= 16'd0;
      ackTimeout         <= 1'b0;
    end else begin
      fireKeyPrev        <= fireKey;
      playerPend         <= playerPendD;
      enemyPend          <= enemyPendD;
      playerCd           <= playerCdD;
      enemyCd            <= enemyCdD;
      playerReady        <= (playerCdD == 8'd0) && !playerPendD;
      shootRequestPlayer <= '0;
      shootRequestEnemy  <= '0;
      if (endLevel) begin
        state  <= IDLE;
        ackCnt <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if ((playerPend || enemyPend) && anyFree) begin
              slot  <= freeIdx;
              state <= REQ;
              if (playerPend) begin
                owner              <= OWNER_PLAYER;
                shootRequestPlayer <= SLOT_ONE << freeIdx;
              end else begin
                owner             <= OWNER_ENEMY;
                shootRequestEnemy <= SLOT_ONE << freeIdx;
              end
            end
          end
          REQ: begin
            state  <= WAIT_ACK;
            ackCnt <= 8'd0;
          end
          WAIT_ACK: begin
            if (ack) begin
              state <= IDLE;
              if (shotCount != 16'hFFFF) shotCount <= shotCount + 16'd1;
            end else if (ackCnt == ACK_LAST) begin
              state      <= IDLE;
              ackTimeout <= 1'b1;
            end else begin
              ackCnt <= ackCnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign dbg = '{state: state, owner: owner, fireKeyPrev: fireKeyPrev, playerPend: playerPend,
                 enemyPend: enemyPend, playerCd: playerCd, enemyCd: enemyCd, ackCnt: ackCnt};

endmodule

// File: doc/shot_dispatcher.md
# shot_dispatcher

Initiator side of the projectile shoot-request protocol. Arbitrates player fire-key presses and enemy fire requests onto a pool of NUM_SLOTS projectile FSM instances, picks a free slot from their beingShot flags, and issues a one-cycle one-hot shootRequestPlayer/shootRequestEnemy pulse to it. It then waits for the slot to acknowledge by raising beingShot. Sits between the keyboard/enemy-control logic and the projectile array, and enforces per-frame cooldowns that scale with level.

## Interface
Parameters:
- NUM_SLOTS, 4, number of projectile FSM instances driven
- PLAYER_COOLDOWN_FRAMES, 8, frames between player shots
- ENEMY_BASE_COOLDOWN, 40, enemy cooldown frames at level 0
- LEVEL_COOLDOWN_STEP, 3, frames removed per level
- ENEMY_MIN_COOLDOWN, 10, floor on enemy cooldown
- ACK_TIMEOUT, 3, cycles to wait for beingShot before retry

Ports:
- Clock and reset: reset resetN, asynchronous, active-low; clock clk.
- startOfFrame  in  1  one-cycle pulse per frame (30 Hz)
- fireKey  in  1  player fire key, level signal, synchronous to clk
- enemyFireReq  in  1  one-cycle enemy fire pulse
- beingShot  in  NUM_SLOTS  per-slot busy flags from projectile FSMs
- level  in  4  current level, unsigned
- endLevel  in  1  level teardown, level-sensitive
- shootRequestPlayer  out  NUM_SLOTS  one-hot player request pulse
- shootRequestEnemy  out  NUM_SLOTS  one-hot enemy request pulse
- playerReady  out  1  player cooldown is 0 and no player request is pending
- shotCount  out  16  acknowledged shots, saturating at 0xFFFF
- ackTimeout  out  1  sticky; set on any ack timeout

## Operation
- Pending latches playerPend and enemyPend:
  - playerPend sets on a fireKey rising edge (registered previous value) while playerCd==0.
  - enemyPend sets on enemyFireReq while enemyCd==0.
  - Requests arriving during a nonzero cooldown are discarded.
- Cooldowns: 8-bit playerCd and enemyCd decrement by 1 on startOfFrame while nonzero.
  - On ack, playerCd loads PLAYER_COOLDOWN_FRAMES.
  - On ack, enemyCd loads max(ENEMY_MIN_COOLDOWN, ENEMY_BASE_COOLDOWN − LEVEL_COOLDOWN_STEP·level). Compute in signed int, then truncate to 8 bits.
- FSM states IDLE, REQ, WAIT_ACK:
  - IDLE: if any pending and a free slot exists (beingShot[i]==0), register slot = lowest free index and owner (player has priority over enemy), then go to REQ. If no slot is free, stay in IDLE and keep the pending latch.
  - REQ: drive bit slot of shootRequestPlayer or shootRequestEnemy, per owner, for exactly this cycle. Go to WAIT_ACK with the timeout counter at 0.
  - WAIT_ACK: if beingShot[slot]==1, this is the ack. Clear the owner's pending latch, load the owner's cooldown, increment shotCount, and go to IDLE. If the counter reaches ACK_TIMEOUT, set ackTimeout and go to IDLE with the pending latch kept, so the request is retried.
- endLevel high: FSM forced to IDLE, pending latches cleared, both cooldowns cleared, no requests driven. shotCount and ackTimeout are retained.
- Simultaneous events:
  - A player edge and enemyFireReq in the same cycle both latch.
  - Player is served first; enemy is served on the next IDLE pass.
  - A startOfFrame in the same cycle as an ack: the load wins.

## Timing
- Reset values: all outputs 0, FSM IDLE, latches and counters 0, previous fireKey 0.
- Request latency: event at cycle t → pending at t+1 → REQ (pulse) at t+2.
- Ack latency: the responder raises beingShot at t+3, and the dispatcher returns to IDLE at t+4.
- Minimum spacing between two requests: 3 cycles (REQ, WAIT_ACK, IDLE).
- Request outputs are decoded from registered state and slot only, so they are glitch-free and never multi-hot.
- Reset mid-operation: immediate return to reset values. Any request pulse in flight is truncated.

## Configuration
- AUTOFIRE_EN defined: while fireKey is held, playerPend also sets whenever playerCd==0, with no edge required. Holding the key yields one shot every PLAYER_COOLDOWN_FRAMES frames.
- AUTOFIRE_EN undefined: playerPend sets on a rising edge only.

## Structure
- Shared package shot_pkg holds:
  - the state enum typedef dispatch_state_t (IDLE, REQ, WAIT_ACK)
  - the owner typedef owner_t (OWNER_PLAYER, OWNER_ENEMY)
  - the cooldown default constants
- One sub-module, free_slot_finder: combinational lowest-index-zero priority encoder over beingShot. Outputs are index and anyFree.

## Test plan
- Reset, then fireKey rises, all slots free → shootRequestPlayer==4'b0001 for one cycle at t+2. Model beingShot[0] at t+3 → shotCount==1, playerCd==8.
- beingShot==4'b0111 and enemyFireReq → shootRequestEnemy==4'b1000. At level 5 the cooldown is 25; at level 12 it is floored to 10.
- fireKey edge and enemyFireReq in the same cycle, all free → player pulse on slot 0, then enemy pulse on slot 1 (with slot 0 acked) 3 cycles later.
- All slots busy with playerPend set → no pulse. Release beingShot[2] → pulse on bit 2.
- No ack modeled → ackTimeout=1 after ACK_TIMEOUT cycles, and the REQ pulse repeats. Assert endLevel → pending cleared, no further pulses.
- Hold fireKey for 40 frames → 1 shot without AUTOFIRE_EN, 5 shots with it.
